// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings and slot record for the register-file hazard/forwarding controller.
package regfile_ctrl_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_BUSY = 1'b1;

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [RA_W-1:0] waddr;
    logic            is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // r0 is hardwired zero, so a write to it must never be visible as a producer.
  function automatic slot_t make_slot(input logic valid, input logic we,
                                      input logic [RA_W-1:0] waddr, input logic is_load);
    slot_t s;
    s.valid   = valid;
    s.we      = valid && we && (waddr != '0);
    s.waddr   = waddr;
    s.is_load = is_load;
    return s;
  endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// Per-operand bypass select and load-use detection against the EX and MEM slots.
module regfile_fwd_sel
  import regfile_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  logic            used,
  input  slot_t           ex,
  input  slot_t           mem,
  output logic [1:0]      sel,
  output logic            load_use
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;
  logic unused_mem_is_load;

  assign src_live = used && (src != '0);
  assign ex_hit   = src_live && ex.valid && ex.we && (ex.waddr == src);
  assign mem_hit  = src_live && mem.valid && mem.we && (mem.waddr == src);

  // A load in EX has no data yet; it only produces load_use, never select 01.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !ex.is_load) sel = FWD_EXE;
    else if (mem_hit)          sel = FWD_MEM;
  end

  assign load_use = ex_hit && ex.is_load;

  assign unused_mem_is_load = mem.is_load;

endmodule

// File: rtl/regfile_hazard_ctrl.sv
// Hazard and forwarding scheduler: tracks EX/MEM destinations, drives bypass selects and stalls.
//   state       | meaning
//   ST_RUN      | normal issue; stalls only on load-use
//   ST_MDU_BUSY | multi-cycle MDU op holds EX; IF/ID stalled, MEM fed bubbles
module regfile_hazard_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            id_we,
  input  logic [RA_W-1:0] id_waddr,
  input  logic            id_is_load,
  input  logic            id_is_mdu,
  input  logic            flush,
  output logic [1:0]      ischangea,
  output logic [1:0]      ischangeb,
  output logic            stall,
  output logic            ex_bubble,
  output logic            mdu_busy
);

  localparam bit             MDU_MULTI = (MDU_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  slot_t            ex_slot;
  slot_t            mem_slot;
  slot_t            id_slot;
  logic             lu_a;
  logic             lu_b;
  logic             load_use;
  logic             mdu_start;

  assign id_slot = make_slot(id_valid, id_we, id_waddr, id_is_load);

  regfile_fwd_sel u_fwd_a (
    .src      (id_rs),
    .used     (id_rs_used),
    .ex       (ex_slot),
    .mem      (mem_slot),
    .sel      (ischangea),
    .load_use (lu_a)
  );

  regfile_fwd_sel u_fwd_b (
    .src      (id_rt),
    .used     (id_rt_used),
    .ex       (ex_slot),
    .mem      (mem_slot),
    .sel      (ischangeb),
    .load_use (lu_b)
  );

  assign load_use = id_valid && (lu_a || lu_b);

  always_comb begin
    stall     = 1'b0;
    ex_bubble = 1'b0;
    mdu_busy  = 1'b0;
    if (state == ST_MDU_BUSY) begin
      stall    = 1'b1;
      mdu_busy = 1'b1;
    end else begin
      stall     = load_use && !flush;
      ex_bubble = stall || flush || !id_valid;
    end
  end

  assign mdu_start = (state == ST_RUN) && !ex_bubble && id_is_mdu && MDU_MULTI;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cnt      <= '0;
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
    end else if (state == ST_RUN) begin
      mem_slot <= ex_slot;
      ex_slot  <= ex_bubble ? SLOT_EMPTY : id_slot;
      if (mdu_start) begin
        state <= ST_MDU_BUSY;
        cnt   <= CNT_INIT;
      end
    end else begin
      mem_slot <= SLOT_EMPTY;
      if (cnt <= CNT_ONE) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule
